// File: rtl/ball_delivery_ctrl_if.sv
// Bundle of the game-side signals of the delivery sequencer: the three sampled
// inputs (game tick, bowl button, bat button) and the LED/score outputs.
interface ball_delivery_ctrl_if #(
  parameter int unsigned PITCH_LEN = 16
);
  logic                 clk_10Hz;
  logic                 bowl_btn;
  logic                 bat_btn;
  logic [PITCH_LEN-1:0] ball_led;
  logic [7:0]           runs;
  logic [2:0]           balls;
  logic [1:0]           result;
  logic                 over_done;
  logic                 busy;

  // Driver side: produces tick and button levels, observes the display outputs.
  modport master (
    output clk_10Hz, bowl_btn, bat_btn,
    input  ball_led, runs, balls, result, over_done, busy
  );

  // Sequencer side.
  modport slave (
    input  clk_10Hz, bowl_btn, bat_btn,
    output ball_led, runs, balls, result, over_done, busy
  );
endinterface

// File: rtl/ball_delivery_ctrl.sv
// Cricket delivery sequencer: synchronises the game tick and buttons, walks the
// ball along the LED pitch, judges bat timing and keeps runs/balls/over state.
module ball_delivery_ctrl #(
  parameter int unsigned PITCH_LEN      = 16,
  parameter int unsigned HIT_POS        = 12,
  parameter int unsigned BALLS_PER_OVER = 6,
  parameter int unsigned HOLD_TICKS     = 10
) (
  input logic                 clk_fpga,
  input logic                 reset,
  ball_delivery_ctrl_if.slave bus_io
);

  localparam int unsigned PosW  = $clog2(PITCH_LEN);
  localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);

  localparam logic [PosW-1:0]      HitLo     = PosW'(HIT_POS);
  localparam logic [PosW-1:0]      HitMid    = PosW'(HIT_POS + 1);
  localparam logic [PosW-1:0]      HitHi     = PosW'(HIT_POS + 2);
  localparam logic [PosW-1:0]      PosLast   = PosW'(PITCH_LEN - 1);
  localparam logic [HoldW-1:0]     HoldLast  = HoldW'(HOLD_TICKS - 1);
  localparam logic [2:0]           BallsFull = 3'(BALLS_PER_OVER);
  localparam logic [PITCH_LEN-1:0] LedOne    = PITCH_LEN'(1);

  localparam logic [1:0] ResNone   = 2'b00;
  localparam logic [1:0] ResHit    = 2'b01;
  localparam logic [1:0] ResEarly  = 2'b10;
  localparam logic [1:0] ResBowled = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StTravel,
    StResult,
    StOver
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisation and rising-edge detection
  // ---------------------------------------------------------------------------
  // Bit order in all three vectors: {tick, bowl, bat}.
  logic [2:0] raw_in;
  logic [2:0] sync0_q, sync1_q, prev_q;
  logic [1:0] warm_q;
  logic       warm;
  logic       tick, bowl, bat;

  assign raw_in = {bus_io.clk_10Hz, bus_io.bowl_btn, bus_io.bat_btn};
  assign warm   = (warm_q == 2'd3);

  // Two-flop synchroniser plus edge history; warm_q masks pulses until the
  // pipeline has refilled after reset so a level already high is not an edge.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      sync0_q <= '0;
      sync1_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
    end else begin
      sync0_q <= raw_in;
      sync1_q <= sync0_q;
      prev_q  <= sync1_q;
      if (!warm) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  // One-cycle pulses on each synchronised rising edge.
  always_comb begin
    tick = sync1_q[2] & ~prev_q[2] & warm;
    bowl = sync1_q[1] & ~prev_q[1] & warm;
    bat  = sync1_q[0] & ~prev_q[0] & warm;
  end

  // ---------------------------------------------------------------------------
  // Sequencer state and registered outputs
  // ---------------------------------------------------------------------------
  state_e               state_q;
  logic [PosW-1:0]      pos_q;
  logic [HoldW-1:0]     hold_q;
  logic [PITCH_LEN-1:0] ball_led_q;
  logic [7:0]           runs_q;
  logic [2:0]           balls_q;
  logic [1:0]           result_q;
  logic                 over_done_q;
  logic                 busy_q;

  logic [1:0]      judge_result;
  logic [7:0]      award;
  logic [8:0]      runs_sum;
  logic [7:0]      runs_sat;
  logic [PosW-1:0] pos_inc;

  // Bat judgement against the current ball position, and saturating run total.
  always_comb begin
    judge_result = ResBowled;
    award        = 8'd0;
    if (pos_q < HitLo) begin
      judge_result = ResEarly;
    end else if (pos_q == HitLo) begin
      judge_result = ResHit;
      award        = 8'd1;
    end else if (pos_q == HitMid) begin
      judge_result = ResHit;
      award        = 8'd4;
    end else if (pos_q == HitHi) begin
      judge_result = ResHit;
      award        = 8'd6;
    end
    runs_sum = {1'b0, runs_q} + {1'b0, award};
    runs_sat = runs_sum[8] ? 8'hFF : runs_sum[7:0];
    pos_inc  = pos_q + PosW'(1);
  end

  // Delivery FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pos_q       <= '0;
      hold_q      <= '0;
      ball_led_q  <= '0;
      runs_q      <= '0;
      balls_q     <= '0;
      result_q    <= ResNone;
      over_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bowl) begin
            state_q    <= StTravel;
            pos_q      <= '0;
            result_q   <= ResNone;
            ball_led_q <= LedOne;
            busy_q     <= 1'b1;
          end
        end

        StTravel: begin
          // A bat press wins over a coincident tick: judged at the current pos.
          if (bat) begin
            state_q  <= StResult;
            result_q <= judge_result;
            runs_q   <= runs_sat;
            balls_q  <= balls_q + 3'd1;
            hold_q   <= '0;
          end else if (tick) begin
            if (pos_q == PosLast) begin
              state_q  <= StResult;
              result_q <= ResBowled;
              balls_q  <= balls_q + 3'd1;
              hold_q   <= '0;
            end else begin
              pos_q      <= pos_inc;
              ball_led_q <= LedOne << pos_inc;
            end
          end
        end

        StResult: begin
          // Ball LED stays frozen until the hold period has elapsed.
          if (tick) begin
            if (hold_q == HoldLast) begin
              hold_q     <= '0;
              ball_led_q <= '0;
              busy_q     <= 1'b0;
              if (balls_q == BallsFull) begin
                state_q     <= StOver;
                over_done_q <= 1'b1;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              hold_q <= hold_q + HoldW'(1);
            end
          end
        end

        StOver: begin
          // Bowl only clears the over; a fresh press is needed to deliver.
          if (bowl) begin
            state_q     <= StIdle;
            balls_q     <= '0;
            over_done_q <= 1'b0;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.ball_led  = ball_led_q;
  assign bus_io.runs      = runs_q;
  assign bus_io.balls     = balls_q;
  assign bus_io.result    = result_q;
  assign bus_io.over_done = over_done_q;
  assign bus_io.busy      = busy_q;

endmodule
